// File: rtl/fir_burst_stim.sv
`default_nettype none
// ============================================================================
// Module   : fir_burst_stim
// Purpose  : Burst stimulus generator for a FIR datapath. Emits bursts of
//            zero / ramp / LFSR / toggle samples separated by idle gaps,
//            for a fixed number of bursts or until stopped.
// Revision : 1.0 - initial release
// ============================================================================
module fir_burst_stim #(
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic [15:0] burst_len,
    input  logic [15:0] gap_len,
    input  logic [7:0]  num_bursts,
    input  logic [1:0]  mode,
    output logic [31:0] outData,
    output logic        data_valid,
    output logic        busy,
    output logic        done,
    output logic [7:0]  burst_cnt
);

    localparam logic [31:0] c_lfsr_mask = 32'h8020_0003;
    localparam logic [31:0] c_tog_hi    = 32'h7FFF_FFFF;
    localparam logic [31:0] c_tog_lo    = 32'h8000_0000;
    localparam logic [1:0]  c_mode_zero = 2'd0;
    localparam logic [1:0]  c_mode_ramp = 2'd1;
    localparam logic [1:0]  c_mode_lfsr = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;            // samples emitted in burst / gap cycles elapsed
    logic [15:0] blen_q, blen_d;
    logic [15:0] glen_q, glen_d;
    logic [7:0]  nb_q, nb_d;
    logic [1:0]  mode_q, mode_d;
    logic [7:0]  burst_cnt_q, burst_cnt_d;
    // Pattern state holds the value for the NEXT sample to be emitted.
    logic [31:0] ramp_q, ramp_d;
    logic [31:0] lfsr_q, lfsr_d;
    logic        tog_q, tog_d;             // 0 -> next toggle sample is 7FFF_FFFF
    logic [31:0] out_data_q, out_data_d;
    logic        data_valid_q, data_valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [15:0] eff_blen;
    logic [7:0]  burst_cnt_inc;
    logic        emit;
    logic        new_burst;
    logic        reseed;
    logic [1:0]  emit_mode;
    logic [31:0] pat_ramp;
    logic [31:0] pat_lfsr;
    logic        pat_tog;

    // Right-shifting Galois LFSR step; mask folds in when a 1 shifts out.
    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        lfsr_step = x[0] ? ((x >> 1) ^ c_lfsr_mask) : (x >> 1);
    endfunction

    assign eff_blen      = (blen_q == 16'd0) ? 16'd1 : blen_q;
    assign burst_cnt_inc = burst_cnt_q + 8'd1;

    // Next-state, counters and registered-output values.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        blen_d       = blen_q;
        glen_d       = glen_q;
        nb_d         = nb_q;
        mode_d       = mode_q;
        burst_cnt_d  = burst_cnt_q;
        ramp_d       = ramp_q;
        lfsr_d       = lfsr_q;
        tog_d        = tog_q;
        out_data_d   = 32'd0;
        data_valid_d = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        emit         = 1'b0;
        new_burst    = 1'b0;
        reseed       = 1'b0;
        emit_mode    = mode_q;
        pat_ramp     = ramp_q;
        pat_lfsr     = lfsr_q;
        pat_tog      = tog_q;

        if (stop) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        blen_d      = burst_len;
                        glen_d      = gap_len;
                        nb_d        = num_bursts;
                        mode_d      = mode;
                        burst_cnt_d = 8'd0;
                        reseed      = 1'b1;
                        emit        = 1'b1;
                        new_burst   = 1'b1;
                        cnt_d       = 16'd1;
                        state_d     = ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (cnt_q == eff_blen) begin
                        burst_cnt_d = burst_cnt_inc;
                        cnt_d       = 16'd1;
                        if ((nb_q != 8'd0) && (burst_cnt_inc == nb_q)) begin
                            state_d = ST_DONE;
                        end else if (glen_q == 16'd0) begin
                            emit      = 1'b1;
                            new_burst = 1'b1;
                        end else begin
                            state_d = ST_GAP;
                        end
                    end else begin
                        emit  = 1'b1;
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == glen_q) begin
                        emit      = 1'b1;
                        new_burst = 1'b1;
                        cnt_d     = 16'd1;
                        state_d   = ST_BURST;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // On start the freshly presented mode and reseeded patterns apply.
        if (reseed) begin
            emit_mode = mode;
            pat_ramp  = 32'd0;
            pat_lfsr  = LFSR_SEED;
        end
        if (new_burst) begin
            pat_tog = 1'b0;
        end

        if (emit) begin
            data_valid_d = 1'b1;
            ramp_d       = pat_ramp + 32'd1;
            lfsr_d       = lfsr_step(pat_lfsr);
            tog_d        = ~pat_tog;
            if (emit_mode == c_mode_zero) begin
                out_data_d = 32'd0;
            end else if (emit_mode == c_mode_ramp) begin
                out_data_d = pat_ramp;
            end else if (emit_mode == c_mode_lfsr) begin
                out_data_d = pat_lfsr;
            end else begin
                out_data_d = pat_tog ? c_tog_lo : c_tog_hi;
            end
        end

        busy_d = (state_d == ST_BURST) || (state_d == ST_GAP);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 16'd0;
            blen_q       <= 16'd0;
            glen_q       <= 16'd0;
            nb_q         <= 8'd0;
            mode_q       <= 2'd0;
            burst_cnt_q  <= 8'd0;
            ramp_q       <= 32'd0;
            lfsr_q       <= LFSR_SEED;
            tog_q        <= 1'b0;
            out_data_q   <= 32'd0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            blen_q       <= blen_d;
            glen_q       <= glen_d;
            nb_q         <= nb_d;
            mode_q       <= mode_d;
            burst_cnt_q  <= burst_cnt_d;
            ramp_q       <= ramp_d;
            lfsr_q       <= lfsr_d;
            tog_q        <= tog_d;
            out_data_q   <= out_data_d;
            data_valid_q <= data_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign outData    = out_data_q;
    assign data_valid = data_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign burst_cnt  = burst_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_burst_stim.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_burst_stim
// Purpose  : Directed self-checking bench for fir_burst_stim.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fir_burst_stim;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic [15:0] burst_len;
    logic [15:0] gap_len;
    logic [7:0]  num_bursts;
    logic [1:0]  mode;
    logic [31:0] outData;
    logic        data_valid;
    logic        busy;
    logic        done;
    logic [7:0]  burst_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Ramp two-burst run: valid pattern and data per cycle after start.
    logic        ramp_v [10] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1};
    logic [31:0] ramp_d [10] = '{0, 1, 2, 3, 0, 0, 4, 5, 6, 7};
    logic [31:0] lfsr_d [3]  = '{32'hACE1_2468, 32'h5670_9234, 32'h2B38_491A};
    logic [31:0] tog_d  [6]  = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF,
                                 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

    fir_burst_stim #(
        .LFSR_SEED (32'hACE1_2468)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .burst_len  (burst_len),
        .gap_len    (gap_len),
        .num_bursts (num_bursts),
        .mode       (mode),
        .outData    (outData),
        .data_valid (data_valid),
        .busy       (busy),
        .done       (done),
        .burst_cnt  (burst_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sampling happens on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, " busy"},  {31'd0, busy}, 32'd0);
        check({tag, " valid"}, {31'd0, data_valid}, 32'd0);
        check({tag, " done"},  {31'd0, done}, 32'd0);
        check({tag, " data"},  outData, 32'd0);
    endtask

    initial begin
        int gap_cycles;
        rst        = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        burst_len  = 16'd0;
        gap_len    = 16'd0;
        num_bursts = 8'd0;
        mode       = 2'd0;
        repeat (3) @(negedge clk);

        // Reset state
        check_idle("reset");
        check("reset burst_cnt", {24'd0, burst_cnt}, 32'd0);
        rst = 1'b1;
        step();
        check_idle("post-reset");

        // Ramp, two bursts with gap; config scrambled and start pulsed while busy
        mode = 2'd1; burst_len = 16'd4; gap_len = 16'd2; num_bursts = 8'd2; start = 1'b1;
        step();
        start = 1'b0; mode = 2'd2; burst_len = 16'd9; gap_len = 16'd0; num_bursts = 8'd7;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("ramp valid %0d", i), {31'd0, data_valid}, {31'd0, ramp_v[i]});
            check($sformatf("ramp data %0d", i), outData, ramp_d[i]);
            check($sformatf("ramp busy %0d", i), {31'd0, busy}, 32'd1);
            start = (i == 4);
            step();
        end
        start = 1'b0;
        check("ramp done", {31'd0, done}, 32'd1);
        check("ramp busy end", {31'd0, busy}, 32'd0);
        check("ramp burst_cnt", {24'd0, burst_cnt}, 32'd2);
        step();
        check("ramp done held", {31'd0, done}, 32'd1);

        // LFSR, single burst, started from DONE
        mode = 2'd2; burst_len = 16'd3; gap_len = 16'd5; num_bursts = 8'd1; start = 1'b1;
        step();
        start = 1'b0;
        check("lfsr done cleared", {31'd0, done}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("lfsr valid %0d", i), {31'd0, data_valid}, 32'd1);
            check($sformatf("lfsr data %0d", i), outData, lfsr_d[i]);
            step();
        end
        check("lfsr done", {31'd0, done}, 32'd1);
        check("lfsr data after", outData, 32'd0);
        check("lfsr burst_cnt", {24'd0, burst_cnt}, 32'd1);

        // Toggle, back-to-back bursts
        mode = 2'd3; burst_len = 16'd3; gap_len = 16'd0; num_bursts = 8'd2; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("tog valid %0d", i), {31'd0, data_valid}, 32'd1);
            check($sformatf("tog data %0d", i), outData, tog_d[i]);
            step();
        end
        check("tog done", {31'd0, done}, 32'd1);
        check("tog burst_cnt", {24'd0, burst_cnt}, 32'd2);

        // Endless run, burst_len 0 treated as 1, then stop
        mode = 2'd1; burst_len = 16'd0; gap_len = 16'd1; num_bursts = 8'd0; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("endless valid %0d", i), {31'd0, data_valid}, {31'd0, ~i[0]});
            check($sformatf("endless data %0d", i), outData, i[0] ? 32'd0 : 32'(i / 2));
            if (i < 7) step();
        end
        check("endless burst_cnt", {24'd0, burst_cnt}, 32'd4);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_idle("after stop");
        check("stop burst_cnt hold", {24'd0, burst_cnt}, 32'd4);
        step();
        check("stop stays idle", {31'd0, busy}, 32'd0);

        // Asynchronous reset in the middle of a gap
        mode = 2'd1; burst_len = 16'd2; gap_len = 16'd5; num_bursts = 8'd0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("gap busy", {31'd0, busy}, 32'd1);
        check("gap valid", {31'd0, data_valid}, 32'd0);
        check("gap burst_cnt", {24'd0, burst_cnt}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check_idle("async reset");
        check("async reset burst_cnt", {24'd0, burst_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) step();
        check_idle("idle after reset");

        // start together with stop in IDLE
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        check_idle("start+stop");
        step();
        check("start+stop stays", {31'd0, busy}, 32'd0);

        // Maximum gap length, zero mode
        mode = 2'd0; burst_len = 16'd1; gap_len = 16'hFFFF; num_bursts = 8'd2; start = 1'b1;
        step();
        start = 1'b0;
        check("zero valid", {31'd0, data_valid}, 32'd1);
        check("zero data", outData, 32'd0);
        gap_cycles = 0;
        step();
        while (!data_valid && gap_cycles < 70000) begin
            gap_cycles++;
            step();
        end
        check("max gap cycles", gap_cycles, 32'd65535);
        check("max gap 2nd valid", {31'd0, data_valid}, 32'd1);
        step();
        check("max gap done", {31'd0, done}, 32'd1);
        check("max gap burst_cnt", {24'd0, burst_cnt}, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fir_burst_stim.md
FIR_BURST_STIM -- requirements
Module: fir_burst_stim

Interface
REQ-001 SHALL have parameter LFSR_SEED, default 32'hACE1_2468, the nonzero LFSR start value.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: begin a burst sequence.
REQ-005 SHALL have port stop, input, 1 bit: abort the sequence.
REQ-006 SHALL have port burst_len, input, 16 bits: samples per burst.
REQ-007 SHALL have port gap_len, input, 16 bits: idle cycles between bursts.
REQ-008 SHALL have port num_bursts, input, 8 bits: burst count; 0 = run until stop.
REQ-009 SHALL have port mode, input, 2 bits: 0 zero, 1 ramp, 2 LFSR, 3 toggle.
REQ-010 SHALL have port outData, output, 32 bits: sample driven to the FIR inData.
REQ-011 SHALL have port data_valid, output, 1 bit: outData carries a burst sample.
REQ-012 SHALL have port busy, output, 1 bit: FSM is in BURST or GAP.
REQ-013 SHALL have port done, output, 1 bit: sticky sequence-complete flag.
REQ-014 SHALL have port burst_cnt, output, 8 bits: count of completed bursts.

Function
REQ-015 SHALL implement FSM states IDLE, BURST, GAP, DONE; all outputs SHALL be registered.
REQ-016 In IDLE or DONE, start=1 SHALL latch burst_len, gap_len, num_bursts and mode, clear burst_cnt and done, reseed pattern state, and enter BURST next cycle; the first sample SHALL appear on that first BURST cycle.
REQ-017 Config inputs SHALL be ignored while busy=1; start SHALL be ignored while busy=1.
REQ-018 A latched burst_len of 0 SHALL be treated as 1.
REQ-019 In BURST, data_valid SHALL be 1 for exactly burst_len consecutive cycles, with one new sample per cycle.
REQ-020 On the last burst sample, burst_cnt SHALL increment, wrapping at 255.
REQ-021 After the last burst sample: if num_bursts!=0 and the new burst_cnt==num_bursts, the FSM SHALL go to DONE; else if gap_len==0, the next burst SHALL start back-to-back with no bubble; else the FSM SHALL go to GAP.
REQ-022 In GAP, the FSM SHALL stay exactly gap_len cycles with outData=0 and data_valid=0, then enter BURST.
REQ-023 In DONE, done SHALL be 1, busy 0, data_valid 0 and outData 0; DONE SHALL be held until start or stop.
REQ-024 stop=1 in any state SHALL force IDLE next cycle and clear outData, data_valid, busy and done; burst_cnt SHALL hold; stop SHALL win over a simultaneous start.
REQ-025 Mode 0 SHALL drive outData=0 with data_valid still asserted per sample.
REQ-026 Mode 1 (ramp) SHALL start at 0 on start, increment by 1 per valid sample modulo 2^32, and continue across bursts without restarting.
REQ-027 Mode 2 (LFSR) SHALL be a 32-bit Galois LFSR with mask 32'h8020_0003, shifting right; when the shifted-out bit is 1, the mask SHALL be XORed in.
REQ-028 Mode 2 SHALL seed to LFSR_SEED on start, output the seed as the first sample, advance once per valid sample, and continue across bursts.
REQ-029 Mode 3 (toggle) SHALL alternate 32'h7FFF_FFFF and 32'h8000_0000 starting with 32'h7FFF_FFFF at every burst start (worst-case FIR switching for droop).
REQ-030 Internal counters SHALL be 16 bits; gap_len=16'hFFFF SHALL yield exactly 65535 gap cycles.

Reset
REQ-031 While rst=0, the block SHALL asynchronously set state=IDLE, outData=0, data_valid=0, busy=0, done=0, burst_cnt=0, ramp=0 and LFSR=LFSR_SEED.
REQ-032 Reset asserted mid-burst SHALL abort immediately; after release the block SHALL stay in IDLE until start.

Verification
REQ-033 Mode 1, burst_len=4, gap_len=2, num_bursts=2, start pulse -> valid samples 0,1,2,3, two idle cycles, then 4,5,6,7; next cycle done=1 and burst_cnt=2.
REQ-034 Mode 2, burst_len=3, num_bursts=1 -> outData sequence 32'hACE1_2468, 32'h5670_9234, 32'h2B38_491A, then done=1.
REQ-035 Mode 3, burst_len=3, gap_len=0, num_bursts=2 -> 7FFFFFFF, 80000000, 7FFFFFFF, 7FFFFFFF, 80000000, 7FFFFFFF on 6 consecutive valid cycles.
REQ-036 num_bursts=0, burst_len=0, gap_len=1: data_valid toggles 1,0 indefinitely; stop -> IDLE next cycle, busy=0, done=0, burst_cnt holds.
REQ-037 rst driven low mid-GAP between clock edges -> all outputs 0 immediately; start together with stop in IDLE -> stays IDLE.
REQ-038 Config inputs changed while busy -> sequence unaffected.
